wb_req_master: RTL

//  Upstream stage of the generated Wishbone register slaves. Turns a simple valid/ready request

---
 rtl/wb_req_master_pkg.sv | 26 ++
 rtl/wb_req_master_timer.sv | 36 +++
 rtl/wb_req_master.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_req_master_pkg.sv
// Shared types for the Wishbone request master: FSM states, response status codes
// and the termination-to-status mapping used by the FSM.
package wb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } t_state;

  typedef enum logic [1:0] {
    STS_OK      = 2'd0,
    STS_ERR     = 2'd1,
    STS_RTY     = 2'd2,
    STS_TIMEOUT = 2'd3
  } t_sts;

  // err outranks rty, rty outranks ack when several terminations arrive together
  function automatic t_sts term_status(input logic err, input logic rty);
    if (err) return STS_ERR;
    if (rty) return STS_RTY;
    return STS_OK;
  endfunction

endpackage

// File: rtl/wb_req_master_timer.sv
// Bus-cycle watchdog: cleared by load_i, counts while en_i, flags expire_o on the
// last permitted cycle (count == TIMEOUT-1) and holds there.
module wb_req_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_req_master.sv
// Single-outstanding Wishbone B4 pipelined master: valid/ready request in, one bus cycle out,
// data and status back. Define WB_REQ_MASTER_RETRY_EN to re-issue on rty up to MAX_RETRY times.
module wb_req_master
  import wb_req_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [31:0]           req_dat_i,
  input  logic [3:0]            req_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_sts_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  t_state                state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic [31:0]           rsp_dat_q, rsp_dat_d;
  t_sts                  rsp_sts_q, rsp_sts_d;
  t_sts                  term_sts;
  logic                  in_bus;
  logic                  accept;
  logic                  term;
  logic                  tmr_load;
  logic                  expire;
  logic                  retry_ok;

  assign in_bus   = (state_q == STROBE) || (state_q == WAIT);
  assign accept   = (state_q == IDLE) && req_valid_i;
  assign term     = wb_ack_i | wb_err_i | wb_rty_i;
  assign term_sts = term_status(wb_err_i, wb_rty_i);

  wb_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (tmr_load),
    .en_i     (in_bus),
    .expire_o (expire)
  );

`ifdef WB_REQ_MASTER_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  logic [RW-1:0] rty_cnt_q, rty_cnt_d;

  assign retry_ok = (rty_cnt_q < RW'(MAX_RETRY));

  // A timer reload while already on the bus can only be a retry re-issue
  always_comb begin
    rty_cnt_d = rty_cnt_q;
    if (accept) begin
      rty_cnt_d = '0;
    end else if (in_bus && tmr_load) begin
      rty_cnt_d = rty_cnt_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rty_cnt_q <= '0;
    end else begin
      rty_cnt_q <= rty_cnt_d;
    end
  end
`else
  logic unused_retry_cfg;
  assign unused_retry_cfg = ^MAX_RETRY;
  assign retry_ok         = 1'b0;
`endif

  // Terminations only count once the strobe has been taken; a termination in the
  // expiry cycle is checked first so it wins over the timeout.
  always_comb begin
    state_d   = state_q;
    rsp_dat_d = rsp_dat_q;
    rsp_sts_d = rsp_sts_q;
    tmr_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d  = STROBE;
          tmr_load = 1'b1;
        end
      end
      STROBE, WAIT: begin
        if (term && ((state_q == WAIT) || !wb_stall_i)) begin
          if ((term_sts == STS_RTY) && retry_ok) begin
            state_d  = STROBE;
            tmr_load = 1'b1;
          end else begin
            state_d   = RESP;
            rsp_sts_d = term_sts;
            rsp_dat_d = ((term_sts == STS_OK) && !we_q) ? wb_dat_i : '0;
          end
        end else if (expire) begin
          state_d   = RESP;
          rsp_sts_d = STS_TIMEOUT;
          rsp_dat_d = '0;
        end else if ((state_q == STROBE) && !wb_stall_i) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_sts_q <= STS_OK;
    end else begin
      state_q   <= state_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_sts_q <= rsp_sts_d;
      if (accept) begin
        we_q  <= req_we_i;
        adr_q <= req_adr_i;
        dat_q <= req_dat_i;
        sel_q <= req_sel_i;
      end
    end
  end

  // Bus controls decode straight from state so an async reset drops cyc/stb at once
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_sts_o   = rsp_sts_q;
  assign wb_cyc_o    = in_bus;
  assign wb_stb_o    = (state_q == STROBE);
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;

endmodule
